// File: rtl/fifo_stream_loop_pkg.sv
// Shared types, default parameters and the per-element step function for
// the fifo_stream_loop kernel.
package fifo_stream_loop_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_N_ITER    = 3;
  localparam int unsigned DEF_ADD_CONST = 2;

  // (add_c + v) + v, wrapping at DEF_WIDTH bits
  function automatic logic [DEF_WIDTH-1:0] step_f(input logic [DEF_WIDTH-1:0] v,
                                                  input int unsigned add_c);
    return (DEF_WIDTH'(add_c) + v) + v;
  endfunction

endpackage

// File: rtl/fifo_stream_loop_if.sv
// Pop-side and push-side FIFO handshake bundle. The master modport is the
// kernel; the slave modport is the FIFO pair around it.
interface fifo_stream_loop_if
  import fifo_stream_loop_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] arg_0_out_data;
  logic             arg_0_read_valid;
  logic             arg_0_read_ready;
  logic [WIDTH-1:0] fifo_1_in_data;
  logic             fifo_1_write_valid;
  logic             fifo_1_write_ready;

  modport master (
    input  arg_0_out_data, arg_0_read_ready, fifo_1_write_ready,
    output arg_0_read_valid, fifo_1_in_data, fifo_1_write_valid
  );

  modport slave (
    output arg_0_out_data, arg_0_read_ready, fifo_1_write_ready,
    input  arg_0_read_valid, fifo_1_in_data, fifo_1_write_valid
  );
endinterface

// File: rtl/fifo_stream_loop_step.sv
// Combinational per-element datapath: res = (ADD_CONST + v) + v, unsigned,
// wrapping at WIDTH bits.
module fifo_stream_loop_step
  import fifo_stream_loop_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned ADD_CONST = DEF_ADD_CONST
) (
  input  logic [WIDTH-1:0] v,
  output logic [WIDTH-1:0] res
);

  // Shared package function covers the default width; other widths inline it.
  if (WIDTH == DEF_WIDTH) begin : g_pkg
    assign res = step_f(v, ADD_CONST);
  end else begin : g_inline
    assign res = (WIDTH'(ADD_CONST) + v) + v;
  end

endmodule

// File: rtl/fifo_stream_loop.sv
// Fixed-trip-count streaming loop body: pops N_ITER words from a show-ahead
// input FIFO, pushes (ADD_CONST + v) + v for each, then raises a sticky valid.
// Optional debug ports (dbg_iter, dbg_stall) under FIFO_STREAM_LOOP_DBG_EN.
//
//   state | meaning
//   READ  | waiting for / popping the next input word
//   WRITE | holding the result on the push side until accepted
//   DONE  | all iterations pushed; valid held until reset
module fifo_stream_loop
  import fifo_stream_loop_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned N_ITER    = DEF_N_ITER,
  parameter int unsigned ADD_CONST = DEF_ADD_CONST
) (
  input  logic clk,
  input  logic rst,
  output logic valid,
`ifdef FIFO_STREAM_LOOP_DBG_EN
  output logic [$clog2(N_ITER):0] dbg_iter,
  output logic                    dbg_stall,
`endif
  fifo_stream_loop_if.master io
);

  localparam int unsigned CW = $clog2(N_ITER) + 1;

  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_WRITE = WRITE;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] step_res;

  fifo_stream_loop_step #(
    .WIDTH     (WIDTH),
    .ADD_CONST (ADD_CONST)
  ) u_step (
    .v   (io.arg_0_out_data),
    .res (step_res)
  );

  // Next-state, iteration count and result register
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      ST_READ: begin
        if (io.arg_0_read_ready) begin
          r_d     = step_res;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (io.fifo_1_write_ready) begin
          if (cnt_q == CW'(N_ITER - 1)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = cnt_q + CW'(1);
            state_d = ST_READ;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_READ;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_READ;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end

  // Strobes decode straight from the registered state, so push data and
  // push valid are stable for the whole WRITE residency.
  assign io.arg_0_read_valid   = (state_q == ST_READ) && io.arg_0_read_ready;
  assign io.fifo_1_write_valid = (state_q == ST_WRITE);
  assign io.fifo_1_in_data     = r_q;
  assign valid                 = (state_q == ST_DONE);

`ifdef FIFO_STREAM_LOOP_DBG_EN
  // The counter stops at N_ITER-1 on the final push, so DONE adds that one.
  assign dbg_iter  = cnt_q + CW'(state_q == ST_DONE);
  assign dbg_stall = rst && (((state_q == ST_READ)  && !io.arg_0_read_ready) ||
                             ((state_q == ST_WRITE) && !io.fifo_1_write_ready));
`endif

endmodule

// File: tb/tb_fifo_stream_loop.sv
// Bench for fifo_stream_loop: queue-based input/output FIFOs around the DUT,
// a count-based reference of the loop contract, randomized feed and
// backpressure on top of directed scenarios.
module tb_fifo_stream_loop;
  import fifo_stream_loop_pkg::*;

  localparam int          N  = 3;
  localparam int unsigned AC = 2;

  typedef struct {
    logic [31:0] w;
    int          gap;
  } feed_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic valid;

  always #5 clk = ~clk;

  fifo_stream_loop_if #(.WIDTH(32)) io ();

`ifdef FIFO_STREAM_LOOP_DBG_EN
  logic [$clog2(N):0] dbg_iter;
  logic               dbg_stall;
`endif

  fifo_stream_loop #(
    .WIDTH     (32),
    .N_ITER    (N),
    .ADD_CONST (AC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid     (valid),
`ifdef FIFO_STREAM_LOOP_DBG_EN
    .dbg_iter  (dbg_iter),
    .dbg_stall (dbg_stall),
`endif
    .io        (io)
  );

  logic [31:0] in_q[$];
  logic [31:0] out_q[$];
  feed_t       feed_q[$];
  int          gap_cnt, block_cnt;
  bit          arm_bp, rand_bp;
  int          push_cnt, pop_cnt;
  logic [31:0] last_pop, last_data;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [31:0] v);
    longint unsigned s;
    s = longint'(AC) + longint'(v) + longint'(v);
    return 32'(s % 64'h1_0000_0000);
  endfunction

  // One clock: feed/drive at negedge, check and account just after it.
  task automatic cycle();
    logic        exp_rv, exp_wv;
    logic [31:0] exp_data;
    @(negedge clk);
    if (feed_q.size() > 0) begin
      if (gap_cnt >= feed_q[0].gap) begin
        in_q.push_back(feed_q[0].w);
        void'(feed_q.pop_front());
        gap_cnt = 0;
      end else begin
        gap_cnt++;
      end
    end
    io.arg_0_read_ready = (in_q.size() > 0);
    io.arg_0_out_data   = (in_q.size() > 0) ? in_q[0] : 32'h0;
    if (arm_bp && pop_cnt > push_cnt) begin
      block_cnt = 5;
      arm_bp    = 1'b0;
    end
    if (block_cnt > 0) begin
      io.fifo_1_write_ready = 1'b0;
      block_cnt--;
    end else begin
      io.fifo_1_write_ready = rand_bp ? ($urandom_range(3) != 0) : 1'b1;
    end
    #1;
    exp_rv   = io.arg_0_read_ready && (pop_cnt == push_cnt) && (push_cnt < N);
    exp_wv   = (pop_cnt > push_cnt);
    exp_data = exp_wv ? ref_f(last_pop) : last_data;
    chk("cyc_valid", valid, push_cnt >= N);
    chk("cyc_read_valid", io.arg_0_read_valid, exp_rv);
    chk("cyc_write_valid", io.fifo_1_write_valid, exp_wv);
    chk("cyc_in_data", io.fifo_1_in_data, exp_data);
    if (io.arg_0_read_valid === 1'b1 && in_q.size() > 0) begin
      last_pop = in_q.pop_front();
      pop_cnt++;
    end
    if (io.fifo_1_write_valid === 1'b1 && io.fifo_1_write_ready) begin
      out_q.push_back(io.fifo_1_in_data);
      last_data = io.fifo_1_in_data;
      push_cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    io.arg_0_read_ready   = 1'b0;
    io.arg_0_out_data     = 32'h0;
    io.fifo_1_write_ready = 1'b0;
    in_q = {};
    feed_q = {};
    block_cnt = 0;
    arm_bp = 1'b0;
    rand_bp = 1'b0;
    gap_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    push_cnt = 0;
    pop_cnt = 0;
    last_data = 32'h0;
    last_pop = 32'h0;
    out_q = {};
    #1;
    chk("rst_valid", valid, 1'b0);
    chk("rst_read_valid", io.arg_0_read_valid, 1'b0);
    chk("rst_write_valid", io.fifo_1_write_valid, 1'b0);
    chk("rst_in_data", io.fifo_1_in_data, 32'h0);
  endtask

  task automatic scenario(input string name, input logic [31:0] words[$], input int gaps[$],
                          input int budget, input bit arm, input bit rbp);
    do_reset();
    foreach (words[i]) feed_q.push_back('{words[i], gaps[i]});
    arm_bp  = arm;
    rand_bp = rbp;
    for (int i = 0; i < budget && valid !== 1'b1; i++) cycle();
    chk({name, "_done"}, valid, 1'b1);
    chk({name, "_out_count"}, out_q.size(), N);
    for (int i = 0; i < N && i < out_q.size(); i++)
      chk({name, "_out_word"}, out_q[i], ref_f(words[i]));
    rand_bp = 1'b0;
    repeat (6) cycle();
    chk({name, "_left_in_fifo"}, in_q.size() + feed_q.size(), words.size() - N);
    if (words.size() > N && in_q.size() > 0)
      chk({name, "_left_word"}, in_q[0], words[N]);
    chk({name, "_pops"}, pop_cnt, N);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    int          g[$];
    io.arg_0_read_ready   = 1'b0;
    io.arg_0_out_data     = 32'h0;
    io.fifo_1_write_ready = 1'b0;

    // reset and idle with an empty input FIFO
    do_reset();
    repeat (10) cycle();
    chk("idle_valid", valid, 1'b0);
    chk("idle_read_valid", io.arg_0_read_valid, 1'b0);
    chk("idle_write_valid", io.fifo_1_write_valid, 1'b0);

    // nominal
    scenario("nominal", '{32'd1, 32'd2, 32'd3}, '{0, 0, 0}, 25, 1'b0, 1'b0);
    chk("nominal_in_empty", in_q.size(), 0);

    // output backpressure for 5 cycles on the first WRITE
    scenario("backpressure", '{32'd1, 32'd2, 32'd3}, '{0, 0, 0}, 40, 1'b1, 1'b0);

    // starved input
    scenario("starved", '{32'd1, 32'd2, 32'd3}, '{0, 10, 0}, 50, 1'b0, 1'b0);

    // over-supply with wraparound
    scenario("wrap", '{32'hFFFF_FFFF, 32'd5, 32'd7, 32'd9}, '{0, 0, 0, 0}, 30, 1'b0, 1'b0);
    chk("wrap_zero", out_q[0], 32'h0);

    // mid-run reset after the first push, then a full fresh run
    do_reset();
    feed_q.push_back('{32'd1, 0});
    feed_q.push_back('{32'd2, 0});
    feed_q.push_back('{32'd3, 0});
    for (int i = 0; i < 20 && push_cnt < 1; i++) cycle();
    chk("midrst_first_push", push_cnt, 1);
    do_reset();
    scenario("after_rst", '{32'd10, 32'd20, 32'd30}, '{0, 0, 0}, 30, 1'b0, 1'b0);

    // randomized words, gaps and backpressure
    for (int r = 0; r < 6; r++) begin
      int n;
      w = {};
      g = {};
      n = N + int'($urandom_range(2));
      for (int k = 0; k < n; k++) begin
        w.push_back($urandom);
        g.push_back(int'($urandom_range(3)));
      end
      scenario("random", w, g, 300, 1'b0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_loop.md
Name: fifo_stream_loop

Overview:
- Fixed-trip-count streaming kernel.
- Pops N_ITER words from an upstream FIFO, computes (ADD_CONST + v) + v for each word, and pushes each result to a downstream FIFO.
- Asserts a sticky valid (done) flag once all iterations complete.
- Sits between two standard show-ahead FIFOs (write_valid/write_ready push side, read_valid/read_ready pop side) as an HLS-style loop body.

Parameters:
- WIDTH, 32, data width of both FIFO data paths.
- N_ITER, 3, number of loop iterations (words consumed and produced); must be >= 1.
- ADD_CONST, 2, constant added in the per-element computation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on rising clk edge; 0 = reset).
- valid  out  1  done flag; 1 after the N_ITER-th result has been pushed, held until reset.
- arg_0_out_data  in  WIDTH  head word of the input FIFO (show-ahead).
- arg_0_read_valid  out  1  pop strobe to the input FIFO; one word popped per cycle it is high.
- arg_0_read_ready  in  1  input FIFO non-empty.
- fifo_1_in_data  out  WIDTH  result word to the output FIFO.
- fifo_1_write_valid  out  1  push strobe to the output FIFO.
- fifo_1_write_ready  in  1  output FIFO not full.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=READ, iteration counter=0, result register=0.
  - valid=0, arg_0_read_valid=0, fifo_1_write_valid=0, fifo_1_in_data=0.
  - Reset mid-operation abandons the current iteration and any held word; no partial push.
- FSM states: READ, WRITE, DONE.
- READ:
  - arg_0_read_valid = arg_0_read_ready (combinational, only in READ).
  - When arg_0_read_ready=1 at the edge: latch r <= (ADD_CONST + arg_0_out_data) + arg_0_out_data, then go to WRITE.
  - Otherwise stay in READ; no pop.
- WRITE:
  - fifo_1_in_data = r; fifo_1_write_valid = 1 (registered/held for the whole state).
  - When fifo_1_write_ready=1 at the edge, the push completes:
    - if counter == N_ITER-1, go to DONE;
    - otherwise counter+1 and return to READ.
  - If fifo_1_write_ready=0, hold r and write_valid (backpressure, no loss).
- DONE:
  - valid=1 (registered); all strobes 0.
  - Input FIFO is no longer popped; remaining words stay in it.
  - Stays in DONE until reset.
- Arithmetic:
  - Sum is computed at WIDTH bits, wrapping modulo 2^WIDTH; unsigned.
  - Counter width: clog2(N_ITER)+1.
- Throughput: 1 word per 2 cycles at best. Latency from pop to push-visible is 1 cycle.
- Push and pop never occur in the same cycle.
- Empty input stalls in READ; full output stalls in WRITE.
- fifo_1_in_data retains its last value outside WRITE.

Optional Feature:
- Macro FIFO_STREAM_LOOP_DBG_EN.
- Defined:
  - Adds output port dbg_iter (width of the counter) giving the number of completed pushes.
  - Adds output port dbg_stall (1 bit), high in any cycle spent in READ with read_ready=0 or in WRITE with write_ready=0.
  - Both ports reset to 0.
- Undefined: these ports and their logic do not exist; core behaviour is identical.

Decomposition:
- Package fifo_stream_loop_pkg holds:
  - state enum {READ, WRITE, DONE};
  - default WIDTH/N_ITER/ADD_CONST constants;
  - a function for the step computation (ADD_CONST + v) + v.
- One sub-module, fifo_stream_loop_step: combinational datapath computing the result from v at WIDTH bits.
- FSM, counter and registers stay in the top module.

Test Plan:
- Reset and idle: hold rst=0 for one edge, release, input FIFO empty → valid=0, arg_0_read_valid=0, fifo_1_write_valid=0 indefinitely.
- Nominal run: push 1,2,3 into the input FIFO on consecutive cycles; output FIFO has space → within 25 cycles valid=1; output FIFO contains 4, 6, 8 in order; input FIFO empty.
- Output backpressure: output FIFO full (write_ready=0) for 5 cycles during WRITE → write_valid and fifo_1_in_data held stable; no result dropped or duplicated; final sequence still 4, 6, 8.
- Starved input: feed 1, wait 10 cycles, then feed 2 and 3 → DUT idles in READ with no pop; results 4, 6, 8; valid only after the third push.
- Over-supply and wrap: feed 0xFFFFFFFF, 5, 7, 9 → outputs 0x00000000, 12, 16; valid=1; word 9 remains in the input FIFO and is never popped.
- Mid-run reset: assert rst=0 after the first push → all outputs 0 and counter cleared; the next run produces a full N_ITER results before valid.
